barrel_shifter_pipe: RTL and testbench



---
 rtl/shifter_pkg.sv | 33 +++
 rtl/shift_stage.sv | 132 +++++++++++++
 rtl/barrel_shifter_pipe.sv | 101 ++++++++++
 tb/tb_barrel_shifter_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shifter_pkg
// Purpose  : Shared types and helpers for the pipelined barrel shifter.
//            Operation encoding, its enum type and a width legality check.
// Revision : 1.0 - initial release
// ============================================================================
package shifter_pkg;

  // Operation encodings as seen on the in_op port.
  localparam logic [1:0] OP_ENC_ROR = 2'b00;
  localparam logic [1:0] OP_ENC_ROL = 2'b01;
  localparam logic [1:0] OP_ENC_SRL = 2'b10;
  localparam logic [1:0] OP_ENC_SRA = 2'b11;

  typedef enum logic [1:0] {
    ROR = OP_ENC_ROR,
    ROL = OP_ENC_ROL,
    SRL = OP_ENC_SRL,
    SRA = OP_ENC_SRA
  } shift_op_t;

  localparam int MIN_WIDTH = 4;
  localparam int MAX_WIDTH = 64;

  // True when the width is a power of two inside the supported range.
  function automatic bit width_ok(input int width);
    return (width >= MIN_WIDTH) && (width <= MAX_WIDTH) &&
           ((width & (width - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
// Module   : shift_stage
// Purpose  : One registered pipeline stage of the barrel shifter. Shifts the
//            upstream operand by 2**STAGE when amount bit STAGE is set, and
//            holds valid/data/remaining amount/op (and carry) for the next
//            stage. Loads whenever load_en is high.
// Ports    : clk, rst_n       - clock, synchronous active-low reset
//            load_en          - stage load enable (computed by the top)
//            up_*             - upstream stage contents
//            valid_o..op_o    - registered stage contents
//            up_carry/carry_o - only with BARREL_SHIFTER_PIPE_CARRY_EN
// Config   : BARREL_SHIFTER_PIPE_CARRY_EN adds the carry register and ports.
// Revision : 1.0 - initial release
// ============================================================================
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STAGE = 0,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic [AW-1:0]    up_amt,
  input  shift_op_t        up_op,
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
  input  logic             up_carry,
  output logic             carry_o,
`endif
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [AW-1:0]    amt_o,
  output shift_op_t        op_o
);

  localparam int SHIFT = 1 << STAGE;
  // Clears the amount bit this stage consumes, leaving the remaining amount.
  localparam logic [AW-1:0] AMT_KEEP = ~(AW'(1) << STAGE);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AW-1:0]    amt_q, amt_d;
  shift_op_t        op_q, op_d;
  logic [WIDTH-1:0] shifted;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
  logic             carry_q, carry_d;
  logic             shifted_carry;
`endif

  // An arithmetic shift never changes the MSB, so up_data[WIDTH-1] is still
  // the original operand sign at every stage.
  always_comb begin
    shifted = up_data;
    if (up_amt[STAGE]) begin
      case (up_op)
        ROR:     shifted = {up_data[SHIFT-1:0], up_data[WIDTH-1:SHIFT]};
        ROL:     shifted = {up_data[WIDTH-SHIFT-1:0], up_data[WIDTH-1:WIDTH-SHIFT]};
        SRL:     shifted = {{SHIFT{1'b0}}, up_data[WIDTH-1:SHIFT]};
        SRA:     shifted = {{SHIFT{up_data[WIDTH-1]}}, up_data[WIDTH-1:SHIFT]};
        default: shifted = up_data;
      endcase
    end
  end

`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
  // The last active stage leaves the final carry: for right-going ops the bit
  // leaving the LSB end (which for ROR lands in the MSB), for ROL the bit
  // that wraps into the LSB.
  always_comb begin
    shifted_carry = up_carry;
    if (up_amt[STAGE]) begin
      shifted_carry = (up_op == ROL) ? up_data[WIDTH-SHIFT] : up_data[SHIFT-1];
    end
  end
`endif

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
    op_d    = op_q;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
    carry_d = carry_q;
`endif
    if (load_en) begin
      valid_d = up_valid;
      // Payload only moves with a real beat; bubbles leave it untouched.
      if (up_valid) begin
        data_d = shifted;
        amt_d  = up_amt & AMT_KEEP;
        op_d   = up_op;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
        carry_d = shifted_carry;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      op_q    <= ROR;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
      carry_q <= carry_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign amt_o   = amt_q;
  assign op_o    = op_q;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
  assign carry_o = carry_q;
`endif

endmodule
`default_nettype wire

// File: rtl/barrel_shifter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : barrel_shifter_pipe
// Purpose  : Pipelined multifunction barrel shifter (ROR/ROL/SRL/SRA) with a
//            valid/ready stream interface, one registered stage per amount
//            bit, bubble-collapsing flow control.
// Ports    : clk, rst_n            - clock, synchronous active-low reset
//            in_valid/in_ready     - input handshake
//            in_data, in_amt, in_op - operand, amount, operation
//            out_valid/out_ready   - output handshake
//            out_data              - result
//            out_carry             - last bit shifted out (carry option only)
// Config   : BARREL_SHIFTER_PIPE_CARRY_EN adds out_carry and carry registers.
// Revision : 1.0 - initial release
// ============================================================================
module barrel_shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
  output logic             out_carry,
`endif
  output logic [WIDTH-1:0] out_data
);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("barrel_shifter_pipe: WIDTH must be a power of two from 4 to 64");
  end

  // Element 0 is the input port; element k+1 is the register of stage k.
  logic             st_valid [AW+1];
  logic [WIDTH-1:0] st_data  [AW+1];
  logic [AW-1:0]    st_amt   [AW+1];
  shift_op_t        st_op    [AW+1];
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
  logic             st_carry [AW+1];
`endif
  logic [AW:0]      load;

  assign st_valid[0] = in_valid;
  assign st_data[0]  = in_data;
  assign st_amt[0]   = in_amt;
  assign st_op[0]    = shift_op_t'(in_op);
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
  assign st_carry[0] = 1'b0;
`endif

  // Bubble-collapsing load chain: a stage loads if it is empty or its
  // successor loads; the last stage's successor is the downstream sink.
  always_comb begin
    load     = '0;
    load[AW] = !st_valid[AW] || out_ready;
    for (int k = AW - 1; k >= 0; k--) begin
      load[k] = !st_valid[k+1] || load[k+1];
    end
  end

  for (genvar k = 0; k < AW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .STAGE (k),
      .AW    (AW)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_en  (load[k]),
      .up_valid (st_valid[k]),
      .up_data  (st_data[k]),
      .up_amt   (st_amt[k]),
      .up_op    (st_op[k]),
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
      .up_carry (st_carry[k]),
      .carry_o  (st_carry[k+1]),
`endif
      .valid_o  (st_valid[k+1]),
      .data_o   (st_data[k+1]),
      .amt_o    (st_amt[k+1]),
      .op_o     (st_op[k+1])
    );
  end

  assign in_ready  = load[0];
  assign out_valid = st_valid[AW];
  assign out_data  = st_data[AW];
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
  assign out_carry = st_carry[AW];
`endif

endmodule
`default_nettype wire

// File: tb/tb_barrel_shifter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_barrel_shifter_pipe
// Purpose  : Scoreboard bench for barrel_shifter_pipe at WIDTH=16. Accepted
//            beats push the expected result; a monitor pops on every consumed
//            result and compares data, carry and latency.
// Config   : BARREL_SHIFTER_PIPE_CARRY_EN enables out_carry checking.
// Revision : 1.0 - initial release
// ============================================================================
module tb_barrel_shifter_pipe;

  localparam int W  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic [AW-1:0] in_amt;
  logic [1:0]    in_op;
  logic          out_carry;

  always #5 clk = ~clk;

  barrel_shifter_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
    .out_carry (out_carry),
`endif
    .out_data  (out_data)
  );
`ifndef BARREL_SHIFTER_PIPE_CARRY_EN
  assign out_carry = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] d;
    logic         c;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t         sb[$];
  int           pop_cyc[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           acc_cnt = 0;
  bit           dir_use = 0;
  logic [W-1:0] dir_d = '0;
  logic         dir_c = 1'b0;
  bit           lat_flag = 0;
  bit           prev_stall = 0;
  logic [W-1:0] prev_data;
  logic         prev_carry;
  exp_t         e_tmp;
  logic [W:0]   m_tmp;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: rotate/shift by plain arithmetic, result {carry, data}.
  function automatic logic [W:0] model(input logic [W-1:0] d, input int a, input logic [1:0] op);
    logic [W-1:0] r;
    logic         c;
    case (op)
      2'd0:    r = (a == 0) ? d : ((d >> a) | (d << (W - a)));
      2'd1:    r = (a == 0) ? d : ((d << a) | (d >> (W - a)));
      2'd2:    r = d >> a;
      default: r = W'($signed(d) >>> a);
    endcase
    if (a == 0)         c = 1'b0;
    else if (op == 2'd0) c = r[W-1];
    else if (op == 2'd1) c = r[0];
    else                c = d[a-1];
    return {c, r};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: handshakes are sampled mid-cycle, where inputs and outputs are
  // both settled for the coming edge.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      sb.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
        check("stall_carry", 32'(out_carry), 32'(prev_carry));
`endif
      end
      if (in_valid && in_ready) begin
        m_tmp     = model(in_data, int'(in_amt), in_op);
        e_tmp.d   = dir_use ? dir_d : m_tmp[W-1:0];
        e_tmp.c   = dir_use ? dir_c : m_tmp[W];
        e_tmp.acc = cyc;
        e_tmp.lat = lat_flag;
        sb.push_back(e_tmp);
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out: got result 0x%0h expected no output (cycle %0d)", out_data, cyc);
        end else begin
          e_tmp = sb.pop_front();
          check("data", 32'(out_data), 32'(e_tmp.d));
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
          check("carry", 32'(out_carry), 32'(e_tmp.c));
`endif
          if (e_tmp.lat) check("latency", 32'(cyc - e_tmp.acc), 32'(AW));
          pop_cyc.push_back(cyc);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_carry = out_carry;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [AW-1:0] a, input logic [1:0] op,
                      input bit lat, input bit use_dir, input logic [W-1:0] ed,
                      input logic ec, output int waits);
    bit got;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_op    = op;
    lat_flag = lat;
    dir_use  = use_dir;
    dir_d    = ed;
    dir_c    = ec;
    waits    = 0;
    got      = 0;
    while (!got && waits < 200) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      waits++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no in_ready after %0d cycles expected acceptance", waits);
    end
    in_valid = 1'b0;
    dir_use  = 0;
  endtask

  task automatic send_rand(input bit lat, output int waits);
    send(W'($urandom), AW'($urandom_range(0, W - 1)), 2'($urandom_range(0, 3)),
         lat, 0, '0, 1'b0, waits);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  logic [W-1:0]  t_d  [9] = '{16'h8001, 16'h8001, 16'h8000, 16'h8000, 16'h00F0,
                              16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3};
  logic [AW-1:0] t_a  [9] = '{4'd1, 4'd4, 4'd15, 4'd15, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0};
  logic [1:0]    t_op [9] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [W-1:0]  t_e  [9] = '{16'hC000, 16'h0018, 16'hFFFF, 16'h0001, 16'h000F,
                              16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3};
  logic          t_c  [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int w;
    int start;
    int drops;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_op     = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_carry", 32'(out_carry), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors, one at a time on an empty pipe.
    for (int i = 0; i < 9; i++) begin
      send(t_d[i], t_a[i], t_op[i], 1, 1, t_e[i], t_c[i], w);
      wait_drain();
    end

    // Backpressure: 8 beats into a stalled sink.
    start     = acc_cnt;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand(0, w);
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        check("bp_accepts", 32'(acc_cnt - start), 32'(AW));
        check("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_total", 32'(acc_cnt - start), 32'd8);

    // Full throughput with the sink always ready.
    pop_cyc.delete();
    drops = 0;
    for (int i = 0; i < 100; i++) begin
      send_rand(0, w);
      if (w != 1) drops++;
    end
    wait_drain();
    check("thru_in_ready_drops", 32'(drops), 32'd0);
    check("thru_count", 32'(pop_cyc.size()), 32'd100);
    if (pop_cyc.size() > 0)
      check("thru_span", 32'(pop_cyc[pop_cyc.size()-1] - pop_cyc[0]), 32'd99);

    // Random sink stalls.
    fork
      begin
        for (int i = 0; i < 60; i++) send_rand(0, w);
      end
      begin
        repeat (150) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) send_rand(0, w);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send_rand(1, w);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
